// File: rtl/lgates_pkg.sv
// Shared definitions for the switch/LED gate demo: gate mode codes and mode count.
package lgates_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_AND   = 3'd0;
    localparam mode_t MODE_OR    = 3'd1;
    localparam mode_t MODE_XOR   = 3'd2;
    localparam mode_t MODE_NAND  = 3'd3;
    localparam mode_t MODE_NOR   = 3'd4;
    localparam mode_t MODE_XNOR  = 3'd5;
    localparam mode_t MODE_NOTA  = 3'd6;
    localparam mode_t MODE_PASSA = 3'd7;

    localparam int NUM_MODES = 8;

endpackage

// File: rtl/lgates_mode_unit_if.sv
// Board-side signal bundle: raw switches and button in, result and mode indicators out.
interface lgates_mode_unit_if #(
    parameter int W = 2
);
    // No valid/ready handshake: inputs are level signals sampled every cycle,
    // outputs are registered levels plus the one-cycle mode_chg pulse.
    logic [2*W-1:0] switch;
    logic           btn;
    logic [W-1:0]   led;
    logic [2:0]     mode_led;
    logic           mode_chg;

    modport master (
        output switch, btn,
        input  led, mode_led, mode_chg
    );

    modport slave (
        input  switch, btn,
        output led, mode_led, mode_chg
    );
endinterface

// File: rtl/lgates_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one raw push-button.
module lgates_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1;
    logic             btn_s;
    logic [CNT_W-1:0] cnt;

    // Any cycle where the synced input agrees with dout restarts the count,
    // so dout only moves after DEB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            sync1 <= din;
            btn_s <= sync1;
            if (btn_s == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                dout <= btn_s;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/lgates_mode_unit.sv
// Gate demo core: synchronised switch operands, button-cycled gate mode, registered LED result.
module lgates_mode_unit
    import lgates_pkg::*;
#(
    parameter int W          = 2,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    lgates_mode_unit_if.slave  io
);
    logic [2*W-1:0] sw_m;
    logic [2*W-1:0] sw_s;
    logic [W-1:0]   a_s;
    logic [W-1:0]   b_s;
    logic [W-1:0]   op_res;
    logic           btn_db;
    logic           btn_dq;
    logic           press;
    mode_t          mode;
    mode_t          mode_nxt;

    lgates_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn_db (
        .clk  (clk),
        .rst  (rst),
        .din  (io.btn),
        .dout (btn_db)
    );

    assign a_s         = sw_s[W-1:0];
    assign b_s         = sw_s[2*W-1:W];
    assign press       = btn_db & ~btn_dq;
    assign mode_nxt    = (mode == mode_t'(NUM_MODES - 1)) ? MODE_AND : mode + 3'd1;
    assign io.mode_led = mode;

    always_comb begin
        op_res = '0;
        case (mode)
            MODE_AND:   op_res = a_s & b_s;
            MODE_OR:    op_res = a_s | b_s;
            MODE_XOR:   op_res = a_s ^ b_s;
            MODE_NAND:  op_res = ~(a_s & b_s);
            MODE_NOR:   op_res = ~(a_s | b_s);
            MODE_XNOR:  op_res = ~(a_s ^ b_s);
            MODE_NOTA:  op_res = ~a_s;
            MODE_PASSA: op_res = a_s;
            default:    op_res = '0;
        endcase
    end

    // led samples the mode register, so a mode step shows on led one edge after mode_led.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_m        <= '0;
            sw_s        <= '0;
            btn_dq      <= 1'b0;
            mode        <= MODE_AND;
            io.led      <= '0;
            io.mode_chg <= 1'b0;
        end else begin
            sw_m        <= io.switch;
            sw_s        <= sw_m;
            btn_dq      <= btn_db;
            io.led      <= op_res;
            io.mode_chg <= press;
            if (press) begin
                mode <= mode_nxt;
            end
        end
    end

endmodule
